instruction_decode: RTL and testbench

//  ID stage of the 64-bit LEGv8 pipeline, directly upstream of Execution. Takes fetched PC/instruction,

---
 rtl/legv8_pkg.sv | 73 +++++++
 rtl/instruction_decode_if.sv | 27 ++
 rtl/register_file.sv | 53 +++++
 rtl/instruction_decode.sv | 143 ++++++++++++++
 tb/tb_instruction_decode.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 instruction decode stage: opcodes,
// ALU control encodings, the XZR index and the ID/EX payload struct.
package legv8_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;

    localparam logic [4:0] XZR = 5'd31;

    // R-type and D-type opcodes live in instr[31:21]
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // I-type opcodes live in instr[31:22]
    localparam logic [9:0] OP_ADDI = 10'b1001000100;
    localparam logic [9:0] OP_SUBI = 10'b1101000100;

    // CB-type opcodes live in instr[31:24]
    localparam logic [7:0] OP_CBZ  = 8'b10110100;
    localparam logic [7:0] OP_CBNZ = 8'b10110101;

    // B-type opcode lives in instr[31:26]
    localparam logic [5:0] OP_B = 6'b000101;

    // Second ALU operand source
    typedef enum logic [1:0] {
        ALUSRC_REG  = 2'b00,
        ALUSRC_SEXT = 2'b01,
        ALUSRC_IMM  = 2'b10
    } alu_src_e;

    // ALU operation class handed to Execution
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_PASS  = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ITYPE = 2'b11
    } alu_op_e;

    // Instruction format / class after decode
    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_R,
        FMT_I,
        FMT_LOAD,
        FMT_STORE,
        FMT_CB,
        FMT_B
    } fmt_e;

    // ID/EX pipeline register payload
    typedef struct packed {
        logic [XLEN-1:0] Address;
        logic [31:0]     Instruction;
        logic [XLEN-1:0] signExtInstr;
        logic [XLEN-1:0] Data1;
        logic [XLEN-1:0] Data2;
        logic [1:0]      ALUSrc;
        logic [1:0]      ALUOp;
        logic            B;
        logic            BZ;
        logic            BNZ;
        logic            MemWrite;
        logic            MemRead;
        logic            MemtoReg;
        logic            RegWrite;
    } id_ex_t;

endpackage

// File: rtl/instruction_decode_if.sv
// Bundle of the IF/ID inputs, writeback port, flush/stall handshake and the
// ID/EX payload. The decode stage is the slave; the surrounding pipeline is master.
interface instruction_decode_if;
    import legv8_pkg::*;

    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            wb_reg_write;
    logic [4:0]      wb_reg;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            stall_out;
    logic            illegal;
    id_ex_t          id_ex;

    modport master (
        output if_valid, if_pc, if_instr, wb_reg_write, wb_reg, wb_data, flush,
        input  stall_out, illegal, id_ex
    );

    modport slave (
        input  if_valid, if_pc, if_instr, wb_reg_write, wb_reg, wb_data, flush,
        output stall_out, illegal, id_ex
    );

endinterface

// File: rtl/register_file.sv
// 32x64 register file: two asynchronous read ports with write-through from
// the single synchronous write port. X31 reads as zero and ignores writes.
module register_file
    import legv8_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rd_addr1_i,
    input  logic [4:0]      rd_addr2_i,
    output logic [XLEN-1:0] rd_data1_o,
    output logic [XLEN-1:0] rd_data2_o,
    input  logic            wr_en_i,
    input  logic [4:0]      wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wrLive;

    assign wrLive = wr_en_i && (wr_addr_i != XZR);

    // Clear everything on reset (dropping any concurrent write), else commit writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wrLive) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port 1: XZR first, then same-cycle writeback bypass, then storage
    always_comb begin
        rd_data1_o = regs_q[rd_addr1_i];
        if (rd_addr1_i == XZR) begin
            rd_data1_o = '0;
        end else if (wrLive && (wr_addr_i == rd_addr1_i)) begin
            rd_data1_o = wr_data_i;
        end
    end

    // Read port 2: same priority as port 1
    always_comb begin
        rd_data2_o = regs_q[rd_addr2_i];
        if (rd_addr2_i == XZR) begin
            rd_data2_o = '0;
        end else if (wrLive && (wr_addr_i == rd_addr2_i)) begin
            rd_data2_o = wr_data_i;
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// LEGv8 ID stage: decodes the IF/ID instruction, reads the register file,
// sign-extends immediates, detects load-use hazards and registers the result
// into the ID/EX pipeline register.
module instruction_decode
    import legv8_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    instruction_decode_if.slave bus
);

    logic [31:0]     instr;
    fmt_e            fmt;
    id_ex_t          ctl;
    id_ex_t          dec;
    logic            legal;
    logic [4:0]      rnAddr;
    logic [4:0]      rmAddr;
    logic [XLEN-1:0] rdData1;
    logic [XLEN-1:0] rdData2;
    logic            rnUsed;
    logic            rmUsed;
    logic [4:0]      exDest;
    logic            hazard;
    logic            stall;
    id_ex_t          id_ex_d;
    id_ex_t          id_ex_q;
    logic            illegal_d;
    logic            illegal_q;

    assign instr = bus.if_instr;

    // Opcode match, control word and immediate extension (no register data here)
    always_comb begin
        fmt                  = FMT_NONE;
        ctl                  = '0;
        ctl.Address          = bus.if_pc;
        ctl.Instruction      = instr;
        if (instr[31:21] inside {OP_ADD, OP_SUB, OP_AND, OP_ORR}) begin
            fmt              = FMT_R;
            ctl.ALUSrc       = ALUSRC_REG;
            ctl.ALUOp        = ALUOP_RTYPE;
            ctl.RegWrite     = 1'b1;
        end else if (instr[31:22] inside {OP_ADDI, OP_SUBI}) begin
            fmt              = FMT_I;
            ctl.ALUSrc       = ALUSRC_IMM;
            ctl.ALUOp        = ALUOP_ITYPE;
            ctl.RegWrite     = 1'b1;
            ctl.signExtInstr = {{(XLEN-12){1'b0}}, instr[21:10]};
        end else if (instr[31:21] == OP_LDUR) begin
            fmt              = FMT_LOAD;
            ctl.ALUSrc       = ALUSRC_SEXT;
            ctl.ALUOp        = ALUOP_ADD;
            ctl.RegWrite     = 1'b1;
            ctl.MemRead      = 1'b1;
            ctl.MemtoReg     = 1'b1;
            ctl.signExtInstr = {{(XLEN-9){instr[20]}}, instr[20:12]};
        end else if (instr[31:21] == OP_STUR) begin
            fmt              = FMT_STORE;
            ctl.ALUSrc       = ALUSRC_SEXT;
            ctl.ALUOp        = ALUOP_ADD;
            ctl.MemWrite     = 1'b1;
            ctl.signExtInstr = {{(XLEN-9){instr[20]}}, instr[20:12]};
        end else if (instr[31:24] inside {OP_CBZ, OP_CBNZ}) begin
            fmt              = FMT_CB;
            ctl.ALUSrc       = ALUSRC_REG;
            ctl.ALUOp        = ALUOP_PASS;
            ctl.BZ           = (instr[31:24] == OP_CBZ);
            ctl.BNZ          = (instr[31:24] == OP_CBNZ);
            ctl.signExtInstr = {{(XLEN-19){instr[23]}}, instr[23:5]};
        end else if (instr[31:26] == OP_B) begin
            fmt              = FMT_B;
            ctl.ALUSrc       = ALUSRC_REG;
            ctl.ALUOp        = ALUOP_ADD;
            ctl.B            = 1'b1;
            ctl.signExtInstr = {{(XLEN-26){instr[25]}}, instr[25:0]};
        end
        legal = (fmt != FMT_NONE);
    end

    // Stores and conditional branches read their data register from Rt in [4:0]
    always_comb begin
        rnAddr = instr[9:5];
        rmAddr = instr[20:16];
        if (fmt inside {FMT_STORE, FMT_CB}) begin
            rmAddr = instr[4:0];
        end
    end

    register_file u_regfile (
        .clk        (clk),
        .rst        (rst),
        .rd_addr1_i (rnAddr),
        .rd_addr2_i (rmAddr),
        .rd_data1_o (rdData1),
        .rd_data2_o (rdData2),
        .wr_en_i    (bus.wb_reg_write),
        .wr_addr_i  (bus.wb_reg),
        .wr_data_i  (bus.wb_data)
    );

    // Merge register operands into the decoded control word
    always_comb begin
        dec       = ctl;
        dec.Data1 = rdData1;
        dec.Data2 = rdData2;
    end

    // Load-use hazard: a load in ID/EX whose destination feeds an operand really used here
    always_comb begin
        rnUsed = legal && (fmt != FMT_B);
        rmUsed = fmt inside {FMT_R, FMT_STORE, FMT_CB};
        exDest = id_ex_q.Instruction[4:0];
        hazard = id_ex_q.MemRead && (exDest != XZR) &&
                 ((rnUsed && (rnAddr == exDest)) || (rmUsed && (rmAddr == exDest)));
        stall  = !rst && bus.if_valid && !bus.flush && hazard;
    end

    // Next ID/EX contents: flush, stall, invalid or undecodable all become a bubble
    always_comb begin
        id_ex_d   = '0;
        illegal_d = bus.if_valid && !legal && !bus.flush;
        if (bus.if_valid && legal && !bus.flush && !stall) begin
            id_ex_d = dec;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            id_ex_q   <= id_ex_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.id_ex     = id_ex_q;
    assign bus.illegal   = illegal_q;
    assign bus.stall_out = stall;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed self-checking bench for the LEGv8 instruction decode stage.
module tb_instruction_decode;

   logic clk;
   logic rst;
   int   nChecks;
   int   nFails;

   instruction_decode_if bus ();

   instruction_decode dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction encoders
   function automatic logic [31:0] encR(input logic [10:0] op, input logic [4:0] rm,
                                        input logic [4:0] rn, input logic [4:0] rd);
      return {op, rm, 6'd0, rn, rd};
   endfunction

   function automatic logic [31:0] encI(input logic [9:0] op, input logic [11:0] imm,
                                        input logic [4:0] rn, input logic [4:0] rd);
      return {op, imm, rn, rd};
   endfunction

   function automatic logic [31:0] encD(input logic [10:0] op, input logic [8:0] addr,
                                        input logic [4:0] rn, input logic [4:0] rt);
      return {op, addr, 2'b00, rn, rt};
   endfunction

   function automatic logic [31:0] encCB(input logic [7:0] op, input logic [18:0] imm,
                                         input logic [4:0] rt);
      return {op, imm, rt};
   endfunction

   function automatic logic [31:0] encB(input logic [25:0] imm);
      return {6'b000101, imm};
   endfunction

   // Drive all master-side inputs of the stage
   task automatic applyStimulus(input logic valid, input logic [63:0] pc, input logic [31:0] ins,
                                input logic fl, input logic wbEn, input logic [4:0] wbReg,
                                input logic [63:0] wbData);
      bus.if_valid     = valid;
      bus.if_pc        = pc;
      bus.if_instr     = ins;
      bus.flush        = fl;
      bus.wb_reg_write = wbEn;
      bus.wb_reg       = wbReg;
      bus.wb_data      = wbData;
   endtask

   // Advance one rising edge and settle past it
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // One comparison point
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      assert (obs === exp)
      else begin
         nFails++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   localparam logic [10:0] ADD  = 11'b10001011000;
   localparam logic [10:0] LDUR = 11'b11111000010;
   localparam logic [10:0] STUR = 11'b11111000000;
   localparam logic [9:0]  ADDI = 10'b1001000100;
   localparam logic [9:0]  SUBI = 10'b1101000100;
   localparam logic [7:0]  CBZ  = 8'b10110100;

   // Directed sequence
   initial begin
      logic [31:0] ins;
      nChecks = 0;
      nFails  = 0;
      rst     = 1'b1;
      applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b1, 5'd10, 64'hAA);

      // Reset held two cycles; a writeback to X10 during reset must be dropped
      cycle();
      checkOutput("rst1_regwrite", 64'(bus.id_ex.RegWrite), 64'd0);
      checkOutput("rst1_stall", 64'(bus.stall_out), 64'd0);
      cycle();
      checkOutput("rst2_payload", 64'(bus.id_ex.Address | bus.id_ex.Data1 | bus.id_ex.Data2), 64'd0);
      checkOutput("rst2_instr", 64'(bus.id_ex.Instruction), 64'd0);
      checkOutput("rst2_illegal", 64'(bus.illegal), 64'd0);
      rst = 1'b0;
      applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 5'd0, 64'd0);
      cycle();
      checkOutput("post_rst_memread", 64'(bus.id_ex.MemRead), 64'd0);

      // X1..X30 all read back as zero after reset
      for (int r = 1; r < 30; r += 2) begin
         applyStimulus(1'b1, 64'h100, encR(ADD, 5'(r + 1), 5'(r), 5'd1), 1'b0, 1'b0, 5'd0, 64'd0);
         cycle();
         checkOutput($sformatf("zero_x%0d", r), bus.id_ex.Data1, 64'd0);
         checkOutput($sformatf("zero_x%0d", r + 1), bus.id_ex.Data2, 64'd0);
      end

      // Writeback X2=5, X3=7, then ADD X1,X2,X3
      applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b1, 5'd2, 64'd5);
      cycle();
      applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b1, 5'd3, 64'd7);
      cycle();
      ins = encR(ADD, 5'd3, 5'd2, 5'd1);
      applyStimulus(1'b1, 64'h10, ins, 1'b0, 1'b0, 5'd0, 64'd0);
      cycle();
      checkOutput("add_data1", bus.id_ex.Data1, 64'd5);
      checkOutput("add_data2", bus.id_ex.Data2, 64'd7);
      checkOutput("add_alusrc", 64'(bus.id_ex.ALUSrc), 64'd0);
      checkOutput("add_aluop", 64'(bus.id_ex.ALUOp), 64'd2);
      checkOutput("add_regwrite", 64'(bus.id_ex.RegWrite), 64'd1);
      checkOutput("add_address", bus.id_ex.Address, 64'h10);
      checkOutput("add_instr", 64'(bus.id_ex.Instruction), 64'(ins));

      // LDUR X4,[X2,#-8] followed by dependent ADD X5,X4,X3
      applyStimulus(1'b1, 64'h14, encD(LDUR, 9'h1F8, 5'd2, 5'd4), 1'b0, 1'b0, 5'd0, 64'd0);
      cycle();
      checkOutput("ldur_memread", 64'(bus.id_ex.MemRead), 64'd1);
      checkOutput("ldur_memtoreg", 64'(bus.id_ex.MemtoReg), 64'd1);
      checkOutput("ldur_alusrc", 64'(bus.id_ex.ALUSrc), 64'd1);
      checkOutput("ldur_aluop", 64'(bus.id_ex.ALUOp), 64'd0);
      checkOutput("ldur_sext", bus.id_ex.signExtInstr, 64'hFFFF_FFFF_FFFF_FFF8);
      checkOutput("ldur_data1", bus.id_ex.Data1, 64'd5);
      ins = encR(ADD, 5'd3, 5'd4, 5'd5);
      applyStimulus(1'b1, 64'h18, ins, 1'b0, 1'b0, 5'd0, 64'd0);
      #1;
      checkOutput("loaduse_stall", 64'(bus.stall_out), 64'd1);
      cycle();
      checkOutput("stall_bubble_regwrite", 64'(bus.id_ex.RegWrite), 64'd0);
      checkOutput("stall_bubble_instr", 64'(bus.id_ex.Instruction), 64'd0);
      checkOutput("stall_released", 64'(bus.stall_out), 64'd0);
      cycle();
      checkOutput("reissue_instr", 64'(bus.id_ex.Instruction), 64'(ins));
      checkOutput("reissue_regwrite", 64'(bus.id_ex.RegWrite), 64'd1);
      checkOutput("reissue_data2", bus.id_ex.Data2, 64'd7);

      // Load to XZR never stalls, even when XZR is read next
      applyStimulus(1'b1, 64'h1C, encD(LDUR, 9'd0, 5'd2, 5'd31), 1'b0, 1'b0, 5'd0, 64'd0);
      cycle();
      applyStimulus(1'b1, 64'h20, encR(ADD, 5'd3, 5'd31, 5'd5), 1'b0, 1'b0, 5'd0, 64'd0);
      #1;
      checkOutput("xzr_load_nostall", 64'(bus.stall_out), 64'd0);
      cycle();
      checkOutput("xzr_load_issue", 64'(bus.id_ex.RegWrite), 64'd1);

      // Load followed by an independent ADDI: no stall
      applyStimulus(1'b1, 64'h24, encD(LDUR, 9'd0, 5'd2, 5'd4), 1'b0, 1'b0, 5'd0, 64'd0);
      cycle();
      applyStimulus(1'b1, 64'h28, encI(ADDI, 12'd1, 5'd2, 5'd6), 1'b0, 1'b0, 5'd0, 64'd0);
      #1;
      checkOutput("indep_nostall", 64'(bus.stall_out), 64'd0);

      // Load followed by STUR storing the loaded register (Rt in [4:0])
      applyStimulus(1'b1, 64'h2C, encD(LDUR, 9'd0, 5'd2, 5'd4), 1'b0, 1'b0, 5'd0, 64'd0);
      cycle();
      applyStimulus(1'b1, 64'h30, encD(STUR, 9'd0, 5'd2, 5'd4), 1'b0, 1'b0, 5'd0, 64'd0);
      #1;
      checkOutput("store_data_stall", 64'(bus.stall_out), 64'd1);
      cycle();
      cycle();
      checkOutput("store_reissue_memwrite", 64'(bus.id_ex.MemWrite), 64'd1);

      // Flush wins over a load-use stall
      applyStimulus(1'b1, 64'h34, encD(LDUR, 9'd0, 5'd2, 5'd4), 1'b0, 1'b0, 5'd0, 64'd0);
      cycle();
      applyStimulus(1'b1, 64'h38, encR(ADD, 5'd3, 5'd4, 5'd5), 1'b1, 1'b0, 5'd0, 64'd0);
      #1;
      checkOutput("flush_over_stall", 64'(bus.stall_out), 64'd0);
      cycle();
      checkOutput("flush_over_stall_bubble", 64'(bus.id_ex.RegWrite), 64'd0);

      // CBZ X9,#-4 at PC 0x40 with X9=0x99
      applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b1, 5'd9, 64'h99);
      cycle();
      applyStimulus(1'b1, 64'h40, encCB(CBZ, 19'h7FFFC, 5'd9), 1'b0, 1'b0, 5'd0, 64'd0);
      cycle();
      checkOutput("cbz_bz", 64'(bus.id_ex.BZ), 64'd1);
      checkOutput("cbz_bnz", 64'(bus.id_ex.BNZ), 64'd0);
      checkOutput("cbz_aluop", 64'(bus.id_ex.ALUOp), 64'd1);
      checkOutput("cbz_sext", bus.id_ex.signExtInstr, 64'hFFFF_FFFF_FFFF_FFFC);
      checkOutput("cbz_data2", bus.id_ex.Data2, 64'h99);
      checkOutput("cbz_address", bus.id_ex.Address, 64'h40);
      checkOutput("cbz_regwrite", 64'(bus.id_ex.RegWrite), 64'd0);

      // Unconditional B with offset -2
      applyStimulus(1'b1, 64'h44, encB(26'h3FF_FFFE), 1'b0, 1'b0, 5'd0, 64'd0);
      cycle();
      checkOutput("b_flag", 64'(bus.id_ex.B), 64'd1);
      checkOutput("b_sext", bus.id_ex.signExtInstr, 64'hFFFF_FFFF_FFFF_FFFE);

      // Write-through: wb X7=0x1234 in the same cycle as SUBI X8,X7,#3
      applyStimulus(1'b1, 64'h48, encI(SUBI, 12'd3, 5'd7, 5'd8), 1'b0, 1'b1, 5'd7, 64'h1234);
      cycle();
      checkOutput("subi_data1", bus.id_ex.Data1, 64'h1234);
      checkOutput("subi_sext", bus.id_ex.signExtInstr, 64'd3);
      checkOutput("subi_alusrc", 64'(bus.id_ex.ALUSrc), 64'd2);
      checkOutput("subi_aluop", 64'(bus.id_ex.ALUOp), 64'd3);

      // ADDI immediate is zero-extended
      applyStimulus(1'b1, 64'h4C, encI(ADDI, 12'hFFF, 5'd7, 5'd8), 1'b0, 1'b0, 5'd0, 64'd0);
      cycle();
      checkOutput("addi_sext_zero", bus.id_ex.signExtInstr, 64'h0000_0000_0000_0FFF);
      checkOutput("addi_data1", bus.id_ex.Data1, 64'h1234);

      // Writes to X31 are ignored, including the bypass path
      applyStimulus(1'b1, 64'h50, encR(ADD, 5'd31, 5'd31, 5'd1), 1'b0, 1'b1, 5'd31, 64'hDEAD);
      cycle();
      checkOutput("xzr_bypass_d1", bus.id_ex.Data1, 64'd0);
      checkOutput("xzr_bypass_d2", bus.id_ex.Data2, 64'd0);
      applyStimulus(1'b1, 64'h54, encR(ADD, 5'd31, 5'd31, 5'd1), 1'b0, 1'b0, 5'd0, 64'd0);
      cycle();
      checkOutput("xzr_after_write", bus.id_ex.Data1, 64'd0);

      // Flush a valid STUR; the regfile write in that cycle still lands
      applyStimulus(1'b1, 64'h58, encD(STUR, 9'd0, 5'd2, 5'd3), 1'b1, 1'b1, 5'd12, 64'h55);
      cycle();
      checkOutput("flush_memwrite", 64'(bus.id_ex.MemWrite), 64'd0);
      checkOutput("flush_instr", 64'(bus.id_ex.Instruction), 64'd0);
      applyStimulus(1'b1, 64'h5C, encD(STUR, 9'd0, 5'd2, 5'd3), 1'b0, 1'b0, 5'd0, 64'd0);
      cycle();
      checkOutput("stur_memwrite", 64'(bus.id_ex.MemWrite), 64'd1);
      checkOutput("stur_data1", bus.id_ex.Data1, 64'd5);
      checkOutput("stur_data2", bus.id_ex.Data2, 64'd7);
      applyStimulus(1'b1, 64'h60, encR(ADD, 5'd31, 5'd12, 5'd1), 1'b0, 1'b0, 5'd0, 64'd0);
      cycle();
      checkOutput("flush_cycle_wb", bus.id_ex.Data1, 64'h55);

      // if_valid=0 yields a bubble even for a decodable word
      applyStimulus(1'b0, 64'h64, encR(ADD, 5'd3, 5'd2, 5'd1), 1'b0, 1'b0, 5'd0, 64'd0);
      cycle();
      checkOutput("invalid_bubble", 64'(bus.id_ex.RegWrite), 64'd0);

      // Undefined opcode: one-cycle illegal pulse and a bubble
      applyStimulus(1'b1, 64'h68, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 64'd0);
      cycle();
      checkOutput("illegal_pulse", 64'(bus.illegal), 64'd1);
      checkOutput("illegal_bubble", 64'(bus.id_ex.Instruction), 64'd0);
      applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 5'd0, 64'd0);
      cycle();
      checkOutput("illegal_clears", 64'(bus.illegal), 64'd0);

      // Flush suppresses illegal
      applyStimulus(1'b1, 64'h6C, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0, 64'd0);
      cycle();
      checkOutput("illegal_flushed", 64'(bus.illegal), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
